// File: rtl/uart_transmitter_if.sv
// ============================================================================
// Module   : uart_transmitter_if
// Brief    : Byte ready/valid handshake between the UART register block and the
//            transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_transmitter_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_transmitter.sv
// ============================================================================
// Module   : uart_transmitter
// Brief    : 8N1 UART serializer, one byte per ready/valid handshake, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  wire              clk,
    input  wire              rst_n,
    uart_transmitter_if.slave bus,
    output logic             serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] c_CNT_READY = CNT_W'(SYMBOL_EDGE_TIME - 2);

    generate
        if (SYMBOL_EDGE_TIME < 2) begin : g_bad_rate
            $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]       r_bit,   w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_tx,    w_tx_nxt;
    logic             r_ready, w_ready_nxt;

    logic w_hs;
    logic w_sym_end;

    assign w_hs      = bus.data_in_valid && r_ready;
    assign w_sym_end = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_ready_nxt = r_ready;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
                if (w_hs) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = bus.data_in;
                    w_tx_nxt    = 1'b0;
                    w_ready_nxt = 1'b0;
                end
            end

            S_START: begin
                if (w_sym_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end

            S_DATA: begin
                if (w_sym_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit != 3'd7) begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit + 3'd1;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end

            S_STOP: begin
                // Ready rises for the last stop-bit cycle so that a waiting
                // producer hands over exactly on the symbol boundary and the
                // next start bit follows with no idle gap.
                if (r_cnt == c_CNT_READY) begin
                    w_ready_nxt = 1'b1;
                end
                if (w_sym_end) begin
                    w_cnt_nxt = '0;
                    if (w_hs) begin
                        w_state_nxt = S_START;
                        w_shift_nxt = bus.data_in;
                        w_tx_nxt    = 1'b0;
                        w_ready_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    assign serial_out        = r_tx;
    assign bus.data_in_ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// Module   : tb_uart_transmitter
// Brief    : Self-checking bench: scoreboard of accepted bytes against a UART
//            receiver model, plus a default-rate bit-timing measurement.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_transmitter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ser_a, ser_b;

    always #5 clk = ~clk;

    uart_transmitter_if ifa ();
    uart_transmitter_if ifb ();

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifa.slave),
        .serial_out (ser_a)
    );

    uart_transmitter u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifb.slave),
        .serial_out (ser_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // cycle counter and handshake monitor feeding the scoreboard
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q_data [$];
    int         q_cyc  [$];
    int         hs_count = 0;
    int         hs_last  = 0;
    int         hs_prev  = 0;

    always @(posedge clk) begin
        if (rst_n && ifa.data_in_valid && ifa.data_in_ready) begin
            q_data.push_back(ifa.data_in);
            q_cyc.push_back(cyc);
            hs_prev = hs_last;
            hs_last = cyc;
            hs_count++;
        end
    end

    // UART receiver model: capture 100 samples per frame, compare to popped byte
    logic       smp [0:99];
    int         n_rx_done = 0;
    int         rx_st;
    bit         rx_abort;
    logic [7:0] rx_exp, rx_got;
    logic [9:0] rx_frame;
    int         rx_t, rx_errs;

    initial begin : rx_model
        forever begin
            @(negedge clk);
            if (rst_n && ser_a === 1'b0) begin
                rx_st    = cyc;
                rx_abort = 1'b0;
                smp[0]   = ser_a;
                for (int i = 1; i < 100; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        rx_abort = 1'b1;
                        break;
                    end
                    smp[i] = ser_a;
                end
                if (!rx_abort) begin
                    chk("rx_expected", int'(q_data.size() > 0), 1);
                    if (q_data.size() > 0) begin
                        rx_exp   = q_data.pop_front();
                        rx_t     = q_cyc.pop_front();
                        rx_frame = {1'b1, rx_exp, 1'b0};
                        rx_errs  = 0;
                        for (int i = 0; i < 100; i++)
                            if (smp[i] !== rx_frame[i/10]) rx_errs++;
                        for (int k = 0; k < 8; k++)
                            rx_got[k] = smp[(k+1)*10 + 5];
                        chk("rx_byte", int'(rx_got), int'(rx_exp));
                        chk("rx_wave_errs", rx_errs, 0);
                        chk("rx_start_cycle", rx_st, rx_t + 1);
                    end
                    n_rx_done++;
                end
            end
        end
    end

    task automatic wait_hs(input int limit);
        int s, t;
        s = hs_count;
        t = 0;
        while (hs_count == s && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("hs_seen", int'(hs_count != s), 1);
    endtask

    // returns at the negedge right after the handshake edge
    task automatic send(input logic [7:0] d, input bit hold);
        @(negedge clk);
        ifa.data_in       = d;
        ifa.data_in_valid = 1'b1;
        wait_hs(2000);
        if (!hold) ifa.data_in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int limit);
        int t;
        t = 0;
        while (n_rx_done < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("rx_done", int'(n_rx_done >= n), 1);
    endtask

    logic sb [0:10859];
    logic rb [0:10859];

    initial begin : stim
        int errs, hs0, cnt;
        ifa.data_in = 8'h00; ifa.data_in_valid = 1'b0;
        ifb.data_in = 8'h00; ifb.data_in_valid = 1'b0;

        // reset asserted mid-cycle takes effect before the next edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_serial", int'(ser_a), 1);
        chk("rst_a_ready",  int'(ifa.data_in_ready), 1);
        chk("rst_b_serial", int'(ser_b), 1);
        chk("rst_b_ready",  int'(ifb.data_in_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (ser_a !== 1'b1 || ifa.data_in_ready !== 1'b1) errs++;
        end
        chk("idle_50_errs", errs, 0);

        // single byte 0xA5, ready window
        send(8'hA5, 1'b0);
        errs = 0;
        if (ifa.data_in_ready !== 1'b0) errs++;
        for (int j = 1; j < 100; j++) begin
            @(negedge clk);
            if (ifa.data_in_ready !== (j == 99)) errs++;
        end
        chk("ready_window_errs", errs, 0);
        wait_rx(1, 300);

        // busy drop: 0xFF offered mid-frame must be ignored
        send(8'h3C, 1'b0);
        hs0 = hs_count;
        repeat (40) @(negedge clk);
        ifa.data_in       = 8'hFF;
        ifa.data_in_valid = 1'b1;
        repeat (5) @(negedge clk);
        ifa.data_in_valid = 1'b0;
        chk("busy_no_hs", hs_count, hs0);
        wait_rx(2, 300);

        // back-to-back 0x00 then 0xFF with valid held
        send(8'h00, 1'b1);
        ifa.data_in = 8'hFF;
        wait_hs(300);
        ifa.data_in_valid = 1'b0;
        chk("b2b_hs_gap", hs_last - hs_prev, 100);
        wait_rx(4, 400);

        // reset in the middle of 0x81
        send(8'h81, 1'b0);
        repeat (35) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_serial", int'(ser_a), 1);
        chk("midrst_ready",  int'(ifa.data_in_ready), 1);
        q_data.delete();
        q_cyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h42, 1'b0);
        wait_rx(5, 300);

        // default rate: 0x55 gives alternating bits of 1085 cycles each
        @(negedge clk);
        chk("b_ready_idle", int'(ifb.data_in_ready), 1);
        ifb.data_in       = 8'h55;
        ifb.data_in_valid = 1'b1;
        @(negedge clk);
        ifb.data_in_valid = 1'b0;
        for (int i = 0; i < 10860; i++) begin
            sb[i] = ser_b;
            rb[i] = ifb.data_in_ready;
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            cnt = 0;
            for (int i = k*1085; i < (k+1)*1085; i++)
                if (sb[i] === logic'(k % 2)) cnt++;
            chk($sformatf("b_bit%0d_len", k), cnt, 1085);
        end
        chk("b_ready_before_end", int'(rb[10848]), 0);
        chk("b_ready_at_end",     int'(rb[10849]), 1);
        errs = 0;
        for (int i = 10850; i < 10860; i++)
            if (sb[i] !== 1'b1) errs++;
        chk("b_idle_after_errs", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
